// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_ctrl
// Purpose  : Command-driven scan controller for a chip-under-test. Generates
//            a divided scan clock, scan enable, test mode and DUT reset, and
//            streams scan vectors in and out over valid/ready handshakes.
//            Commands: SHIFT (n scan cycles), CAPTURE (one functional pulse),
//            DUT_RESET (hold csoc_rstn low), SET_TM (load test mode bit).
// Ports    : clk, rstn                  - system clock, async active-low reset
//            cmd_valid/ready/op/len     - command handshake and payload
//            si_valid/ready/data        - scan-in vector stream
//            so_valid/so_data           - scan-out vector strobe
//            busy, done                 - command status
//            csoc_clk/rstn/test_se/tm   - DUT control outputs (registered)
//            csoc_si / csoc_so          - DUT scan chain data
// Revision : 1.0 - initial release
// ============================================================================
module scan_chain_ctrl #(
    parameter  int N_CHAINS   = 1,
    parameter  int CHAIN_LEN  = 256,
    parameter  int CLK_DIV    = 4,
    parameter  int RST_CYCLES = 16,
    localparam int LEN_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                si_valid,
    output logic                si_ready,
    input  logic [N_CHAINS-1:0] si_data,
    output logic                so_valid,
    output logic [N_CHAINS-1:0] so_data,
    output logic                busy,
    output logic                done,
    output logic                csoc_clk,
    output logic                csoc_rstn,
    output logic                csoc_test_se,
    output logic                csoc_test_tm,
    output logic [N_CHAINS-1:0] csoc_si,
    input  logic [N_CHAINS-1:0] csoc_so
);

    localparam int c_PH_W = $clog2(CLK_DIV);
    // Reset hold counts half-periods of csoc_clk; bit 0 selects the level.
    localparam int c_RC_W = $clog2(2 * RST_CYCLES);

    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(CLK_DIV - 1);
    localparam logic [c_PH_W-1:0] c_PH_ONE  = c_PH_W'(1);
    localparam logic [c_RC_W-1:0] c_RC_LAST = c_RC_W'(2 * RST_CYCLES - 1);
    localparam logic [c_RC_W-1:0] c_RC_ONE  = c_RC_W'(1);
    localparam logic [LEN_W-1:0]  c_LEN_MAX = LEN_W'(CHAIN_LEN);
    localparam logic [LEN_W-1:0]  c_LEN_ONE = LEN_W'(1);

    localparam logic [1:0] c_OP_SHIFT     = 2'd0;
    localparam logic [1:0] c_OP_CAPTURE   = 2'd1;
    localparam logic [1:0] c_OP_DUT_RESET = 2'd2;
    localparam logic [1:0] c_OP_SET_TM    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SH_LOW   = 3'd1,
        S_SH_HIGH  = 3'd2,
        S_CAP_LOW  = 3'd3,
        S_CAP_HIGH = 3'd4,
        S_RST_HOLD = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_PH_W-1:0]   r_phase;
    logic [c_PH_W-1:0]   w_phase_nxt;
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    w_cnt_nxt;
    logic [c_RC_W-1:0]   r_rcnt;
    logic [c_RC_W-1:0]   w_rcnt_nxt;
    logic                r_init;
    logic                r_csoc_clk;
    logic                r_csoc_rstn;
    logic                r_se;
    logic                r_tm;
    logic [N_CHAINS-1:0] r_si;
    logic [N_CHAINS-1:0] r_so_data;
    logic                r_so_valid;

    logic                w_cmd_acc;
    logic                w_si_acc;
    logic                w_ph_last;
    logic                w_so_cap;
    logic                w_clk_nxt;
    logic [LEN_W-1:0]    w_len_clamp;

    // r_init keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready    = (r_state == S_IDLE) && r_init;
    // Vectors are only taken on the first cycle of a shift low phase; the
    // phase counter holds at zero until one arrives.
    assign si_ready     = (r_state == S_SH_LOW) && (r_phase == '0);
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign so_valid     = r_so_valid;
    assign so_data      = r_so_data;
    assign csoc_clk     = r_csoc_clk;
    assign csoc_rstn    = r_csoc_rstn;
    assign csoc_test_se = r_se;
    assign csoc_test_tm = r_tm;
    assign csoc_si      = r_si;

    assign w_cmd_acc   = cmd_valid && cmd_ready;
    assign w_si_acc    = si_valid && si_ready;
    assign w_ph_last   = (r_phase == c_PH_LAST);
    assign w_len_clamp = (cmd_len > c_LEN_MAX) ? c_LEN_MAX : cmd_len;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_cnt   <= '0;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_rcnt_nxt  = r_rcnt;
        w_so_cap    = 1'b0;
        w_clk_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_acc) begin
                    w_phase_nxt = '0;
                    w_rcnt_nxt  = '0;
                    case (cmd_op)
                        c_OP_SHIFT: begin
                            if (w_len_clamp == '0) begin
                                w_state_nxt = S_DONE;
                            end else begin
                                w_state_nxt = S_SH_LOW;
                                w_cnt_nxt   = w_len_clamp;
                            end
                        end
                        c_OP_CAPTURE:   w_state_nxt = S_CAP_LOW;
                        c_OP_DUT_RESET: w_state_nxt = S_RST_HOLD;
                        default:        w_state_nxt = S_DONE;
                    endcase
                end
            end
            S_SH_LOW: begin
                // Phase 0 is never the last phase since CLK_DIV >= 2.
                if (w_ph_last) begin
                    w_phase_nxt = '0;
                    w_so_cap    = 1'b1;
                    w_state_nxt = S_SH_HIGH;
                end else if ((r_phase != '0) || si_valid) begin
                    w_phase_nxt = r_phase + c_PH_ONE;
                end
            end
            S_SH_HIGH: begin
                if (w_ph_last) begin
                    w_phase_nxt = '0;
                    w_cnt_nxt   = r_cnt - c_LEN_ONE;
                    w_state_nxt = (r_cnt == c_LEN_ONE) ? S_DONE : S_SH_LOW;
                end else begin
                    w_phase_nxt = r_phase + c_PH_ONE;
                end
            end
            S_CAP_LOW: begin
                if (w_ph_last) begin
                    w_phase_nxt = '0;
                    w_state_nxt = S_CAP_HIGH;
                end else begin
                    w_phase_nxt = r_phase + c_PH_ONE;
                end
            end
            S_CAP_HIGH: begin
                if (w_ph_last) begin
                    w_phase_nxt = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_phase_nxt = r_phase + c_PH_ONE;
                end
            end
            S_RST_HOLD: begin
                if (w_ph_last) begin
                    w_phase_nxt = '0;
                    if (r_rcnt == c_RC_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_rcnt_nxt = r_rcnt + c_RC_ONE;
                    end
                end else begin
                    w_phase_nxt = r_phase + c_PH_ONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // csoc_clk is registered from the next-state decode so it toggles
        // cleanly in step with the state register.
        w_clk_nxt = (w_state_nxt == S_SH_HIGH) || (w_state_nxt == S_CAP_HIGH) ||
                    ((w_state_nxt == S_RST_HOLD) && w_rcnt_nxt[0]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_init      <= 1'b0;
            r_csoc_clk  <= 1'b0;
            r_csoc_rstn <= 1'b0;
            r_se        <= 1'b0;
            r_tm        <= 1'b0;
            r_si        <= '0;
            r_so_data   <= '0;
            r_so_valid  <= 1'b0;
        end else begin
            r_init      <= 1'b1;
            r_csoc_clk  <= w_clk_nxt;
            r_csoc_rstn <= (w_state_nxt != S_RST_HOLD);
            r_se        <= (w_state_nxt == S_SH_LOW) || (w_state_nxt == S_SH_HIGH);
            r_so_valid  <= w_so_cap;
            if (w_cmd_acc && (cmd_op == c_OP_SET_TM)) begin
                r_tm <= cmd_len[0];
            end
            if (w_si_acc) begin
                r_si <= si_data;
            end
            if (w_so_cap) begin
                r_so_data <= csoc_so;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_chain_ctrl
// Purpose  : Self-checking bench for scan_chain_ctrl. A passive monitor logs
//            csoc_clk level runs, scan-out strobes and done pulses; each test
//            task predicts those logs from the command it issued.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_chain_ctrl;
    localparam int NC    = 2;
    localparam int CL    = 8;
    localparam int CD    = 4;
    localparam int RC    = 16;
    localparam int LEN_W = $clog2(CL + 1);

    localparam logic [1:0] OP_SHIFT = 2'd0;
    localparam logic [1:0] OP_CAP   = 2'd1;
    localparam logic [1:0] OP_RST   = 2'd2;
    localparam logic [1:0] OP_TM    = 2'd3;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             si_valid = 1'b0;
    logic             si_ready;
    logic [NC-1:0]    si_data = '0;
    logic             so_valid;
    logic [NC-1:0]    so_data;
    logic             busy;
    logic             done;
    logic             csoc_clk;
    logic             csoc_rstn;
    logic             csoc_test_se;
    logic             csoc_test_tm;
    logic [NC-1:0]    csoc_si;
    logic [NC-1:0]    csoc_so;
    logic [NC-1:0]    tb_xor = '0;

    // The DUT's scan chain is modelled as a wire loop with an optional
    // inversion pattern, so scan-out must equal the applied vector ^ tb_xor.
    assign csoc_so = csoc_si ^ tb_xor;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NC-1:0] tb_vec[16];
    int            tb_stall[16];

    // ---------------- monitor ----------------
    int            mon_rises = 0;
    int            mon_done  = 0;
    int            mon_run   = 0;
    logic          mon_prev  = 1'b0;
    int            mon_low_log[$];
    int            mon_high_log[$];
    logic          mon_se_log[$];
    logic [NC-1:0] mon_so_log[$];

    always #5 clk = ~clk;

    scan_chain_ctrl #(
        .N_CHAINS  (NC),
        .CHAIN_LEN (CL),
        .CLK_DIV   (CD),
        .RST_CYCLES(RC)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .si_valid    (si_valid),
        .si_ready    (si_ready),
        .si_data     (si_data),
        .so_valid    (so_valid),
        .so_data     (so_data),
        .busy        (busy),
        .done        (done),
        .csoc_clk    (csoc_clk),
        .csoc_rstn   (csoc_rstn),
        .csoc_test_se(csoc_test_se),
        .csoc_test_tm(csoc_test_tm),
        .csoc_si     (csoc_si),
        .csoc_so     (csoc_so)
    );

    always @(negedge clk) begin
        if (so_valid === 1'b1) mon_so_log.push_back(so_data);
        if (done === 1'b1) mon_done++;
        if (csoc_clk !== mon_prev) begin
            if (csoc_clk === 1'b1) begin
                mon_rises++;
                mon_se_log.push_back(csoc_test_se);
                mon_low_log.push_back(mon_run);
            end else begin
                mon_high_log.push_back(mon_run);
            end
            mon_run = 1;
        end else begin
            mon_run++;
        end
        if (busy !== 1'b1) mon_run = 0;
        mon_prev = csoc_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len);
        int t;
        t = 0;
        @(negedge clk);
        cmd_op = op; cmd_len = len; cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_len   = LEN_W'($urandom);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_timeout: done=%b required 1", name, done);
        end
        repeat (2) @(negedge clk);
    endtask

    // Runs a SHIFT; expectations follow from the command alone: min(len,CL)
    // pulses, one strobe per vector carrying vec^tb_xor, low phases of CD
    // plus any stall, high phases of CD, scan enable high at each rise.
    task automatic run_shift(input int len_cmd, input logic [NC-1:0] xorv, input string name);
        int eff, s_rise, s_done, s_so, s_low, s_high, t, got;
        eff    = (len_cmd > CL) ? CL : len_cmd;
        tb_xor = xorv;
        s_rise = mon_rises;
        s_done = mon_done;
        s_so   = mon_so_log.size();
        s_low  = mon_low_log.size();
        s_high = mon_high_log.size();
        send_cmd(OP_SHIFT, LEN_W'(len_cmd));
        if (eff == 0) begin
            @(negedge clk);
            n_tests++;
            if (done !== 1'b1) begin
                n_fail++;
                $display("FAIL %s done_next_cycle: done=%b required 1", name, done);
            end
        end else begin
            for (int i = 0; i < eff; i++) begin
                t = 0;
                @(negedge clk);
                while (si_ready !== 1'b1 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                repeat (tb_stall[i]) @(negedge clk);
                si_data = tb_vec[i]; si_valid = 1'b1;
                @(posedge clk); #1;
                si_valid = 1'b0; si_data = NC'($urandom);
            end
        end
        wait_done(name);
        n_tests++;
        if (mon_rises - s_rise !== eff) begin
            n_fail++;
            $display("FAIL %s pulses: got %0d required %0d", name, mon_rises - s_rise, eff);
        end
        n_tests++;
        if (mon_so_log.size() - s_so !== eff) begin
            n_fail++;
            $display("FAIL %s so_valid_count: got %0d required %0d", name, mon_so_log.size() - s_so, eff);
        end
        n_tests++;
        if (mon_done - s_done !== 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d required 1", name, mon_done - s_done);
        end
        for (int i = 0; i < eff; i++) begin
            n_tests++;
            if (s_so + i >= mon_so_log.size() || mon_so_log[s_so + i] !== (tb_vec[i] ^ xorv)) begin
                n_fail++;
                $display("FAIL %s so_data[%0d]: got %b required %b", name, i,
                         (s_so + i < mon_so_log.size()) ? mon_so_log[s_so + i] : 'x, tb_vec[i] ^ xorv);
            end
            got = (s_low + i < mon_low_log.size()) ? mon_low_log[s_low + i] : -1;
            n_tests++;
            if (got !== CD + tb_stall[i]) begin
                n_fail++;
                $display("FAIL %s low_len[%0d]: got %0d required %0d", name, i, got, CD + tb_stall[i]);
            end
            got = (s_high + i < mon_high_log.size()) ? mon_high_log[s_high + i] : -1;
            n_tests++;
            if (got !== CD) begin
                n_fail++;
                $display("FAIL %s high_len[%0d]: got %0d required %0d", name, i, got, CD);
            end
            n_tests++;
            if (s_low + i >= mon_se_log.size() || mon_se_log[s_low + i] !== 1'b1) begin
                n_fail++;
                $display("FAIL %s se_at_rise[%0d]: got 0 required 1", name, i);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [12:0] outs;
        repeat (3) @(negedge clk);
        outs = {csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, csoc_si, so_data,
                so_valid, done, busy, si_ready, cmd_ready};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0", outs);
        end
        rstn = 1'b1;
        #1;
        n_tests++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_before_edge: got %b required 0", cmd_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({csoc_rstn, cmd_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_first_edge: rstn/ready got %b required 11", {csoc_rstn, cmd_ready});
        end
    endtask

    task automatic test_shift_basic();
        tb_vec[0] = 2'b01; tb_vec[1] = 2'b10; tb_vec[2] = 2'b11;
        for (int i = 0; i < 16; i++) tb_stall[i] = 0;
        run_shift(3, 2'b00, "shift3");
    endtask

    task automatic test_shift_zero();
        run_shift(0, 2'b00, "shift0");
    endtask

    task automatic test_shift_stall();
        tb_vec[0] = 2'b10; tb_vec[1] = 2'b01;
        tb_stall[0] = 0; tb_stall[1] = 10;
        run_shift(2, 2'b00, "stall");
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 16; i++) begin
            tb_vec[i] = NC'($urandom); tb_stall[i] = 0;
        end
        run_shift(12, 2'b01, "clamp");
    endtask

    task automatic test_random_shift();
        int len;
        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(1, 15);
            for (int i = 0; i < 16; i++) begin
                tb_vec[i]   = NC'($urandom);
                tb_stall[i] = $urandom_range(0, 3);
            end
            run_shift(len, NC'($urandom), $sformatf("rand%0d", k));
        end
    endtask

    task automatic test_capture();
        int s_rise, s_done, s_so, s_low;
        logic [NC-1:0] si_before;
        s_rise = mon_rises; s_done = mon_done;
        s_so = mon_so_log.size(); s_low = mon_low_log.size();
        si_before = csoc_si;
        si_valid = 1'b1; si_data = ~csoc_si;
        send_cmd(OP_CAP, LEN_W'($urandom));
        wait_done("capture");
        si_valid = 1'b0;
        n_tests++;
        if (mon_rises - s_rise !== 1) begin
            n_fail++;
            $display("FAIL capture_pulses: got %0d required 1", mon_rises - s_rise);
        end
        n_tests++;
        if (s_low >= mon_se_log.size() || mon_se_log[s_low] !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_se: got 1 required 0");
        end
        n_tests++;
        if (mon_so_log.size() - s_so !== 0) begin
            n_fail++;
            $display("FAIL capture_so_valid: got %0d required 0", mon_so_log.size() - s_so);
        end
        n_tests++;
        if (mon_done - s_done !== 1) begin
            n_fail++;
            $display("FAIL capture_done: got %0d required 1", mon_done - s_done);
        end
        n_tests++;
        if (csoc_si !== si_before) begin
            n_fail++;
            $display("FAIL capture_si_ignored: got %b required %b", csoc_si, si_before);
        end
    endtask

    task automatic test_set_tm();
        logic [LEN_W-1:0] l;
        for (int k = 0; k < 2; k++) begin
            l = LEN_W'($urandom);
            l[0] = (k == 0);
            send_cmd(OP_TM, l);
            @(negedge clk);
            n_tests++;
            if (done !== 1'b1) begin
                n_fail++;
                $display("FAIL set_tm_done: got %b required 1", done);
            end
            repeat (2) @(negedge clk);
            n_tests++;
            if (csoc_test_tm !== (k == 0)) begin
                n_fail++;
                $display("FAIL set_tm_value%0d: got %b required %b", k, csoc_test_tm, k == 0);
            end
        end
    endtask

    task automatic test_dut_reset();
        int s_rise, s_done, low_cnt, t;
        s_rise = mon_rises; s_done = mon_done;
        low_cnt = 0; t = 0;
        send_cmd(OP_RST, LEN_W'($urandom));
        @(negedge clk);
        while (done !== 1'b1 && t < 1000) begin
            if (csoc_rstn === 1'b0) low_cnt++;
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (csoc_rstn !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL dut_reset_release: rstn=%b done=%b required 1 1", csoc_rstn, done);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (low_cnt !== 2 * RC * CD) begin
            n_fail++;
            $display("FAIL dut_reset_low_cycles: got %0d required %0d", low_cnt, 2 * RC * CD);
        end
        n_tests++;
        if (mon_rises - s_rise !== RC) begin
            n_fail++;
            $display("FAIL dut_reset_pulses: got %0d required %0d", mon_rises - s_rise, RC);
        end
        n_tests++;
        if (mon_done - s_done !== 1) begin
            n_fail++;
            $display("FAIL dut_reset_done: got %0d required 1", mon_done - s_done);
        end
    endtask

    task automatic test_async_reset();
        int t, s_done;
        logic [12:0] outs;
        send_cmd(OP_SHIFT, LEN_W'(5));
        t = 0;
        @(negedge clk);
        while (si_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        si_data = 2'b11; si_valid = 1'b1;
        @(posedge clk); #1;
        si_valid = 1'b0;
        t = 0;
        while (csoc_clk !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        n_tests++;
        if (csoc_clk !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach_high: csoc_clk got %b required 1", csoc_clk);
        end
        s_done = mon_done;
        #2 rstn = 1'b0;
        #1;
        outs = {csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, csoc_si, so_data,
                so_valid, done, busy, si_ready, cmd_ready};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b required 0", outs);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (mon_done - s_done !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d required 0", mon_done - s_done);
        end
        tb_vec[0] = 2'b01; tb_vec[1] = 2'b11;
        tb_stall[0] = 1; tb_stall[1] = 0;
        run_shift(2, 2'b10, "after_abort");
    endtask

    initial begin
        test_reset();
        test_shift_basic();
        test_shift_zero();
        test_shift_stall();
        test_capture();
        test_set_tm();
        test_dut_reset();
        test_clamp();
        test_random_shift();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 Parameter N_CHAINS, default 1, number of parallel scan chains (1..8).
REQ-002 Parameter CHAIN_LEN, default 256, maximum shift count per command; LEN_W = clog2(CHAIN_LEN+1).
REQ-003 Parameter CLK_DIV, default 4, clk cycles per csoc_clk phase (>=2).
REQ-004 Parameter RST_CYCLES, default 16, csoc_clk periods that csoc_rstn is held low for a DUT reset.
REQ-005 clk  in  1  system clock; single clock domain, all logic on rising edge.
REQ-006 rstn  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; a command is accepted when both are high on the same clk edge.
REQ-008 cmd_op  in  2  command: 0 SHIFT, 1 CAPTURE, 2 DUT_RESET, 3 SET_TM.
REQ-009 cmd_len  in  LEN_W  number of shift cycles for SHIFT; bit 0 is the tm value for SET_TM; ignored otherwise.
REQ-010 si_valid / si_ready  in / out  1 / 1  scan-in vector handshake.
REQ-011 si_data  in  N_CHAINS  scan-in bits, bit i to chain i.
REQ-012 so_valid  out  1  one-cycle strobe qualifying so_data; no backpressure.
REQ-013 so_data  out  N_CHAINS  scan-out bits captured from csoc_so.
REQ-014 busy / done  out  1 / 1  command in progress / one-cycle completion strobe.
REQ-015 csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm  out  1 each  DUT clock, DUT reset, scan enable, test mode.
REQ-016 csoc_si  out  N_CHAINS  DUT scan inputs; csoc_so  in  N_CHAINS  DUT scan outputs.

Function
REQ-017 States: IDLE, SH_LOW, SH_HIGH, CAP_LOW, CAP_HIGH, RST_HOLD, DONE; cmd_ready=1 only in IDLE.
REQ-018 SHIFT with cmd_len>0: IDLE->SH_LOW with csoc_test_se=1 and count=cmd_len; SHIFT with cmd_len=0 goes directly to DONE with no csoc_clk pulse.
REQ-019 SH_LOW: csoc_clk=0; si_ready=1 on the first cycle of the phase; if si_valid=0, the block stalls in SH_LOW with the phase counter frozen until a vector is accepted.
REQ-020 On si acceptance, csoc_si<=si_data and remains stable until the next acceptance; the low phase then runs CLK_DIV cycles.
REQ-021 On the last cycle of SH_LOW, csoc_so is registered into so_data and so_valid pulses once; transition to SH_HIGH.
REQ-022 SH_HIGH: csoc_clk=1 for CLK_DIV cycles; count decrements on exit; count=0 -> DONE, otherwise -> SH_LOW.
REQ-023 CAPTURE: csoc_test_se=0; CAP_LOW for CLK_DIV cycles, then CAP_HIGH for CLK_DIV cycles (exactly one csoc_clk pulse); then DONE; no so_valid.
REQ-024 DUT_RESET: csoc_rstn=0 for RST_CYCLES full csoc_clk periods (clock keeps toggling), then csoc_rstn=1 and DONE.
REQ-025 SET_TM: csoc_test_tm<=cmd_len[0] on acceptance; then DONE; csoc_test_tm holds until the next SET_TM or reset.
REQ-026 DONE: done=1 for exactly one cycle, csoc_test_se=0, csoc_clk=0; next state IDLE.
REQ-027 busy=1 in every state except IDLE.
REQ-028 csoc_clk is a registered output, glitch-free, duty cycle exactly 50% except during si stalls (extended low).
REQ-029 Phase counter width is clog2(CLK_DIV); shift counter width is LEN_W; cmd_len>CHAIN_LEN is clamped to CHAIN_LEN.
REQ-030 cmd_valid while busy is ignored (not latched); si_valid outside SH_LOW is ignored.

Reset
REQ-031 rstn low asynchronously forces: state IDLE, csoc_clk=0, csoc_rstn=0, csoc_test_se=0, csoc_test_tm=0, csoc_si=0, so_data=0, so_valid=0, done=0, busy=0, si_ready=0, cmd_ready=0.
REQ-032 The first clk edge after rstn deasserts sets csoc_rstn=1 and cmd_ready=1; reset mid-command aborts it without a done pulse.

Verification
REQ-033 N_CHAINS=2, CLK_DIV=4: SHIFT len=3, si vectors 01,10,11, csoc_so looped to csoc_si -> three csoc_clk pulses, 8-cycle period, so_valid x3 with so_data 01,10,11, done once.
REQ-034 SHIFT len=0 -> done on the cycle after acceptance, csoc_clk never rises, so_valid never asserted.
REQ-035 SHIFT len=2 with si_valid withheld 10 cycles before the second vector -> csoc_clk stays low during the stall, exactly 2 pulses total.
REQ-036 CAPTURE -> csoc_test_se=0, exactly one csoc_clk pulse, done; SET_TM len=1 then len=0 -> csoc_test_tm 1 then 0.
REQ-037 DUT_RESET with RST_CYCLES=16, CLK_DIV=4 -> csoc_rstn low for 128 clk cycles, then high, done.
REQ-038 rstn asserted during SH_HIGH of SHIFT len=5 -> all outputs immediately at reset values, no done; new SHIFT after release completes normally.
